// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller and its decoder.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  function automatic logic [6:0] seg_code(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Host-side and display-side signals of the scan controller, plus FSM state for observation.
interface seg7_scan_ctrl_if;
  import seg7_pkg::*;

  // load is a one-cycle strobe with no back-pressure: every cycle with load=1 is accepted
  // and captures digit_in/dp_in; there is no ready signal.
  logic        en;
  logic        load;
  logic [15:0] digit_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;
  state_t      dbg_state;

  modport master (
    output en, load, digit_in, dp_in,
    input  seg, dp, an, frame_done, dbg_state
  );

  modport slave (
    input  en, load, digit_in, dp_in,
    output seg, dp, an, frame_done, dbg_state
  );

endinterface

// File: rtl/seg7_scan_ctrl_hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment decoder, shared by display blocks.
module hex_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = seg_code(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with blank guard per slot and
// double-buffered value that is only swapped at frame boundaries.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic           clk,
  input  logic           rst_n,
  seg7_scan_ctrl_if.slave bus
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          commit;
  logic          fd_d;

  logic [15:0]   act_val_q, pend_val_q;
  logic [3:0]    act_dp_q, pend_dp_q;
  logic          pend_valid_q;

  logic [3:0]    nib;
  logic [6:0]    dec_seg;
  logic [6:0]    seg_d, seg_q;
  logic [3:0]    an_d, an_q;
  logic          dp_d, dp_q;
  logic          fd_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    commit  = 1'b0;
    fd_d    = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = '0;
          commit  = 1'b1;
        end
        BLANK: begin
          // The counter runs straight through into SHOW; only slot end clears it.
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == BLANK_LAST) state_d = SHOW;
        end
        SHOW: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              fd_d   = 1'b1;
              commit = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state values so they line up with state/idx.
  assign nib = act_val_q[{idx_d, 2'b00} +: 4];

  hex_to_7seg u_dec (
    .nibble (nib),
    .seg    (dec_seg)
  );

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = AN_OFF;
    dp_d  = 1'b1;
    if (state_d == SHOW) begin
      seg_d = dec_seg;
      an_d  = ~(4'b0001 << idx_d);
      dp_d  = ~act_dp_q[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= AN_OFF;
      dp_q    <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
      fd_q    <= fd_d;
    end
  end

  // A load landing on a commit cycle bypasses pending and goes straight to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_val_q    <= '0;
      act_dp_q     <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
    end else if (commit && (bus.load || pend_valid_q)) begin
      act_val_q    <= bus.load ? bus.digit_in : pend_val_q;
      act_dp_q     <= bus.load ? bus.dp_in    : pend_dp_q;
      pend_valid_q <= 1'b0;
    end else if (bus.load) begin
      pend_val_q   <= bus.digit_in;
      pend_dp_q    <= bus.dp_in;
      pend_valid_q <= 1'b1;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = fd_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: per-slot scoreboard of {an,seg,dp},
// plus blank/lit timing, one-hot anode and frame_done period monitors.
module tb_seg7_scan_ctrl;
  import seg7_pkg::*;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int LIT   = SLOT - BLANK;
  localparam int FRAME = 4 * SLOT;

  logic clk = 1'b0;
  logic rst_n;

  seg7_scan_ctrl_if bus();

  seg7_scan_ctrl #(
    .SLOT_CYCLES  (SLOT),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  logic        mon_on   = 1'b0;
  logic        skip_len = 1'b0;
  logic [3:0]  prev_an  = 4'hF;
  logic [11:0] cur_slot = '0;
  logic [11:0] mon_exp;
  int          lit_len  = 0;
  int          last_fd  = -1;
  int          fd_count = 0;
  int          cyc      = 0;

  function automatic logic [6:0] exp_code(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Monitor: every cycle checks anode exclusivity and dark outputs; pops one
  // expectation per lit slot and checks the slot holds steady for LIT cycles.
  always @(negedge clk) begin
    cyc++;
    if (mon_on) begin
      checks++;
      if ($countones(~bus.an) > 1) begin
        errors++;
        $display("FAIL two_hot: an=%b required at most one low bit", bus.an);
      end
      if (bus.an == 4'hF) begin
        checks++;
        if (bus.seg !== SEG_BLANK || bus.dp !== 1'b1) begin
          errors++;
          $display("FAIL dark_out: seg=%b dp=%b required seg=1111111 dp=1", bus.seg, bus.dp);
        end
      end
      if (prev_an != 4'hF && bus.an != prev_an && !skip_len) begin
        checks++;
        if (lit_len != LIT) begin
          errors++;
          $display("FAIL lit_len: an=%b lit for %0d cycles required %0d", prev_an, lit_len, LIT);
        end
      end
      if (bus.an != 4'hF && bus.an != prev_an) begin
        cur_slot = {bus.an, bus.seg, bus.dp};
        lit_len  = 1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL slot_unexpected: got an=%b seg=%b dp=%b required no lit slot",
                   bus.an, bus.seg, bus.dp);
        end else begin
          mon_exp = exp_q.pop_front();
          if (cur_slot !== mon_exp) begin
            errors++;
            $display("FAIL slot: got an=%b seg=%b dp=%b required an=%b seg=%b dp=%b",
                     bus.an, bus.seg, bus.dp, mon_exp[11:8], mon_exp[7:1], mon_exp[0]);
          end
        end
      end else if (bus.an != 4'hF) begin
        lit_len++;
        checks++;
        if ({bus.an, bus.seg, bus.dp} !== cur_slot) begin
          errors++;
          $display("FAIL lit_hold: got %b required %b", {bus.an, bus.seg, bus.dp}, cur_slot);
        end
      end
      if (bus.frame_done === 1'b1) begin
        fd_count++;
        if (last_fd >= 0) begin
          checks++;
          if (cyc - last_fd != FRAME) begin
            errors++;
            $display("FAIL frame_period: got %0d cycles required %0d", cyc - last_fd, FRAME);
          end
        end
        last_fd = cyc;
      end
      if (!bus.en) last_fd = -1;
      prev_an = bus.an;
    end else begin
      prev_an = 4'hF;
      lit_len = 0;
      last_fd = -1;
    end
  end

  task automatic push_digit(input logic [15:0] v, input logic [3:0] dpv, input int d);
    logic [3:0] a;
    a    = 4'hF;
    a[d] = 1'b0;
    exp_q.push_back({a, exp_code(v[d*4 +: 4]), ~dpv[d]});
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] dpv);
    for (int d = 0; d < 4; d++) push_digit(v, dpv, d);
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] dpv);
    @(negedge clk);
    bus.digit_in = v;
    bus.dp_in    = dpv;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] target);
    int n = 0;
    while (bus.an !== target && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.an !== target) begin
      errors++;
      $display("FAIL wait_an: an=%b after %0d cycles required %b", bus.an, n, target);
    end
  endtask

  // Runs until every expected slot has been shown and the last one went dark, then stops scanning.
  task automatic drain();
    int n = 0;
    while (!(exp_q.size() == 0 && bus.an == 4'hF) && n < 400) begin
      @(negedge clk);
      n++;
    end
    bus.en = 1'b0;
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL drain_timeout: %0d slots still expected after %0d cycles required 0",
               exp_q.size(), n);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    rst_n  = 1'b0;
    bus.en = 1'b1;
    repeat (3) @(negedge clk);
    checks += 5;
    if (bus.seg !== SEG_BLANK) begin errors++; $display("FAIL rst_seg: got %b required 1111111", bus.seg); end
    if (bus.an !== AN_OFF)     begin errors++; $display("FAIL rst_an: got %b required 1111", bus.an); end
    if (bus.dp !== 1'b1)       begin errors++; $display("FAIL rst_dp: got %b required 1", bus.dp); end
    if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL rst_fd: got %b required 0", bus.frame_done); end
    if (bus.dbg_state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d required IDLE", bus.dbg_state); end
    rst_n = 1'b1;
    n = 0;
    while (bus.an == 4'hF && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks += 2;
    if (n != BLANK + 1) begin
      errors++;
      $display("FAIL rst_first_lit: an[0] low after %0d cycles required %0d", n, BLANK + 1);
    end
    if (bus.an !== 4'hE || bus.seg !== exp_code(4'h0)) begin
      errors++;
      $display("FAIL rst_first_digit: an=%b seg=%b required an=1110 seg=%b", bus.an, bus.seg, exp_code(4'h0));
    end
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_scan_order();
    int fd0;
    drive_load(16'h4321, 4'b0000);
    push_frame(16'h4321, 4'b0000);
    push_frame(16'h4321, 4'b0000);
    mon_on = 1'b1;
    fd0 = fd_count;
    @(negedge clk);
    bus.en = 1'b1;
    drain();
    checks++;
    if (fd_count - fd0 != 2) begin
      errors++;
      $display("FAIL frame_done_count: got %0d pulses required 2", fd_count - fd0);
    end
  endtask

  task automatic test_tear_free();
    push_frame(16'h4321, 4'b0000);
    bus.en = 1'b1;
    wait_an(4'hD);
    drive_load(16'hFFFF, 4'b0000);
    push_frame(16'hFFFF, 4'b0000);
    drain();
  endtask

  task automatic test_back_to_back();
    push_frame(16'hFFFF, 4'b0000);
    bus.en = 1'b1;
    wait_an(4'hE);
    drive_load(16'hAAAA, 4'b0000);
    drive_load(16'h0000, 4'b0000);
    push_frame(16'h0000, 4'b0000);
    drain();
  endtask

  task automatic test_enable_drop();
    drive_load(16'hB6E9, 4'b0000);
    for (int d = 0; d < 3; d++) push_digit(16'hB6E9, 4'b0000, d);
    bus.en = 1'b1;
    wait_an(4'hB);
    @(negedge clk);
    skip_len = 1'b1;
    bus.en   = 1'b0;
    @(negedge clk);
    checks += 4;
    if (bus.an !== AN_OFF)     begin errors++; $display("FAIL drop_an: got %b required 1111", bus.an); end
    if (bus.seg !== SEG_BLANK) begin errors++; $display("FAIL drop_seg: got %b required 1111111", bus.seg); end
    if (bus.dbg_state !== IDLE) begin errors++; $display("FAIL drop_state: got %0d required IDLE", bus.dbg_state); end
    if (exp_q.size() != 0)     begin errors++; $display("FAIL drop_queue: %0d slots pending required 0", exp_q.size()); end
    repeat (2) @(negedge clk);
    skip_len = 1'b0;
    push_frame(16'hB6E9, 4'b0000);
    bus.en = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid_slot();
    push_frame(16'hB6E9, 4'b0000);
    bus.en = 1'b1;
    wait_an(4'hE);
    repeat (2) @(negedge clk);
    mon_on = 1'b0;
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    checks += 5;
    if (bus.an !== AN_OFF)       begin errors++; $display("FAIL async_an: got %b required 1111", bus.an); end
    if (bus.seg !== SEG_BLANK)   begin errors++; $display("FAIL async_seg: got %b required 1111111", bus.seg); end
    if (bus.dp !== 1'b1)         begin errors++; $display("FAIL async_dp: got %b required 1", bus.dp); end
    if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL async_fd: got %b required 0", bus.frame_done); end
    if (bus.dbg_state !== IDLE)  begin errors++; $display("FAIL async_state: got %0d required IDLE", bus.dbg_state); end
    bus.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // The active buffer was cleared by reset, so a bare enable shows zeros.
    mon_on = 1'b1;
    push_frame(16'h0000, 4'b0000);
    bus.en = 1'b1;
    drain();
  endtask

  task automatic test_dp();
    drive_load(16'h0000, 4'b0101);
    push_frame(16'h0000, 4'b0101);
    bus.en = 1'b1;
    drain();
  endtask

  task automatic test_random();
    logic [15:0] v;
    logic [3:0]  dpv;
    for (int k = 0; k < 3; k++) begin
      v   = 16'($urandom_range(0, 65535));
      dpv = 4'($urandom_range(0, 15));
      drive_load(v, dpv);
      push_frame(v, dpv);
      bus.en = 1'b1;
      drain();
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.load     = 1'b0;
    bus.digit_in = '0;
    bus.dp_in    = '0;
    test_reset();
    test_scan_order();
    test_tear_free();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_slot();
    test_dp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a 4-digit common-anode 7-segment display whose digits share one segment bus. It holds a 16-bit hex value (four nibbles) and cycles a digit index 0→3. Each nibble is decoded to active-low segments, and one active-low anode is driven at a time. A blanking guard between digits suppresses ghosting, and new values are applied only at frame boundaries so the display never tears.

## Interface
- SLOT_CYCLES, default 50000: clock cycles per digit slot (blank guard plus lit time); legal range 4..2^20.
- BLANK_CYCLES, default 500: cycles at the start of each slot with all anodes off; legal range 1..SLOT_CYCLES-2.
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  scan enable; when low, the display is dark.
- load  input  1  single-cycle strobe that captures digit_in/dp_in into the pending buffer.
- digit_in  input  16  four hex nibbles; [3:0] is digit 0, [15:12] is digit 3.
- dp_in  input  4  decimal points; bit i belongs to digit i; 1 = lit.
- seg  output  7  active-low segments, order {g,f,e,d,c,b,a}.
- dp  output  1  active-low decimal point.
- an  output  4  active-low anode enables; at most one bit is low at any time.
- frame_done  output  1  one-cycle pulse when the slot for digit 3 ends.

## Operation
- Three registers: active buffer (16+4 bits), pending buffer (16+4 bits) with a pend_valid flag, and the digit index idx[1:0].
- State machine states:
  - IDLE: display dark.
  - BLANK: all anodes off for BLANK_CYCLES.
  - SHOW: anode idx on for SLOT_CYCLES-BLANK_CYCLES.
- IDLE→BLANK when en=1. Entry sets idx=0 and the slot counter to 0. If pend_valid is set, pending is committed to active on entry.
- BLANK→SHOW when the slot counter reaches BLANK_CYCLES-1. The slot counter keeps counting across the transition.
- SHOW→BLANK when the slot counter reaches SLOT_CYCLES-1. The slot counter clears and idx increments modulo 4.
- When idx wraps 3→0:
  - frame_done pulses.
  - If pend_valid is set, pending is committed to active in the same cycle and pend_valid clears.
- Any state→IDLE on the cycle after en=0. idx and the counter clear; the active buffer is retained.
- load capture:
  - load=1 writes pending and sets pend_valid, even while in IDLE.
  - Repeated loads before a commit overwrite pending; the last value wins.
  - If load coincides with a commit cycle, the new load data is committed directly and pend_valid ends 0.
- Decode: active nibble idx through the hex decoder, covering 0-F. Codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- dp = ~active_dp[idx] in SHOW, 1 otherwise.
- seg = 7'b1111111 in IDLE and BLANK.

## Timing
- Reset values:
  - State: IDLE.
  - seg = 7'b1111111, dp = 1, an = 4'b1111, frame_done = 0.
  - idx = 0, active buffer = 0, pend_valid = 0.
- All outputs are registered. An output reflects the state/idx of the previous cycle's transition; there are no combinational paths from inputs to outputs.
- After en rises at cycle t: BLANK is entered at t+1, and an[0] goes low at t+1+BLANK_CYCLES.
- Frame period: 4*SLOT_CYCLES cycles. frame_done is high for exactly one cycle per frame, coincident with the cycle idx becomes 0.
- Reset asserted mid-frame forces reset values asynchronously. The first frame after release starts only once en is high.
- Slot counter width: $clog2(SLOT_CYCLES); it never exceeds SLOT_CYCLES-1.

## Structure
- Package seg7_pkg holds:
  - state enum {IDLE, BLANK, SHOW};
  - the constants SEG_BLANK = 7'h7F and AN_OFF = 4'hF;
  - the 16-entry segment code table as a function.
- Sub-module hex_to_7seg: combinational, 4-bit in, 7-bit active-low out. Reused by other display blocks.
- Expected size ~150-200 RTL lines.

## Test plan
- Reset check: hold rst_n=0 with en=1 → seg=7F, an=F, dp=1, frame_done=0. Release → first an[0] low exactly BLANK_CYCLES+1 cycles after en is sampled high.
- Scan order: SLOT=8, BLANK=2, load 0x4321 with dp_in=0, then en=1 → per slot, an cycles E,D,B,7 with seg 1111001, 0100100, 0110000, 0011001. Each slot has 2 dark cycles then 6 lit cycles; frame_done pulses every 32 cycles.
- Tear-free update: load 0xFFFF during the digit 1 SHOW of a 0x4321 frame → digits 2 and 3 still show 3 and 4. The next frame shows F (0001110) on all digits.
- Back-to-back loads: load 0xAAAA, then 0x0000 two cycles later in the same frame → next frame shows 0 (1000000) on all digits; 0xAAAA is never displayed.
- Enable drop and reset mid-slot: en=0 during SHOW → next cycle an=F, seg=7F. en=1 restarts at digit 0 with the retained value. rst_n pulse mid-slot → outputs at reset values immediately, with no clock edge needed.
- dp check: dp_in=4'b0101 → dp low only during the SHOW phases of digits 0 and 2; an is never two-hot in any cycle.
